// File: rtl/db9md_pad_reader.sv
// DB9 Mega Drive / Genesis pad reader.
// Scans two pads through a shared 6-line port: player 1 (8 select steps),
// player 2 (8 select steps), then a long idle gap with SELECT high so that
// six-button pads drop back to their first read state. Each player's 16-bit
// button word is rewritten in a single clock once its scan completes.
module db9md_pad_reader #(
  parameter int CLK_DIV    = 400,
  parameter int IDLE_STEPS = 160
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  joy_in,
  output logic        joy_mdsel,
  output logic        joy_split,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2
);

  localparam logic [15:0] CNT_MAX  = 16'(CLK_DIV - 1);
  localparam logic [9:0]  IDLE_MAX = 10'(IDLE_STEPS - 1);
  localparam logic [9:0]  SCAN_MAX = 10'd7;

  typedef enum logic [1:0] {PH_P1, PH_P2, PH_IDLE} phase_e;

  // input synchronizer; an all-ones line pair means "nothing pressed"
  logic [5:0]  sync1_q, sync1_d;
  logic [5:0]  sync2_q, sync2_d;
  logic [5:0]  raw;

  // scan sequencer
  phase_e      phase_q, phase_d;
  logic [9:0]  step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic        step_end;
  logic        sample_en;

  // registered pad control lines
  logic        mdsel_q, mdsel_d;
  logic        split_q, split_d;

  // per-step captures; only the lines the decoder looks at are kept
  logic [5:0]  cap0_q, cap0_d;   // raw[5:0] at step 0
  logic [3:0]  cap1_q, cap1_d;   // raw[5:2] at step 1
  logic [3:0]  cap5_q, cap5_d;   // raw[3:0] at step 5
  logic [3:0]  cap6_q, cap6_d;   // raw[3:0] at step 6

  // update strobe, issued the clock after the step-7 sample
  logic        upd_q, upd_d;
  logic        upd_p2_q, upd_p2_d;

  // decoded word and output registers
  logic        present;
  logic        six;
  logic [15:0] word;
  logic [15:0] joy1_q, joy1_d;
  logic [15:0] joy2_q, joy2_d;

  assign raw = ~sync2_q;

  // synchronizer next values
  always_comb begin
    sync1_d = joy_in;
    sync2_d = sync1_q;
  end

  // synchronizer flops, idle-high so raw reads as released during reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 6'h3F;
      sync2_q <= 6'h3F;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_P1;
      step_q  <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  // sequencer next state: steps advance only when the step counter wraps
  always_comb begin
    step_end = (cnt_q == CNT_MAX);
    cnt_d    = step_end ? 16'd0 : 16'(cnt_q + 16'd1);
    phase_d  = phase_q;
    step_d   = step_q;
    if (step_end) begin
      step_d = 10'(step_q + 10'd1);
      case (phase_q)
        PH_P1: begin
          if (step_q == SCAN_MAX) begin
            phase_d = PH_P2;
            step_d  = '0;
          end
        end
        PH_P2: begin
          if (step_q == SCAN_MAX) begin
            phase_d = PH_IDLE;
            step_d  = '0;
          end
        end
        PH_IDLE: begin
          if (step_q == IDLE_MAX) begin
            phase_d = PH_P1;
            step_d  = '0;
          end
        end
        default: begin
          phase_d = PH_P1;
          step_d  = '0;
        end
      endcase
    end
  end

  // pad control lines derived from the state being entered, so they only
  // move on the wrap clock; SELECT is high on even scan steps and in idle
  always_comb begin
    mdsel_d = 1'b1;
    split_d = 1'b0;
    case (phase_d)
      PH_P1:   mdsel_d = ~step_d[0];
      PH_P2: begin
        mdsel_d = ~step_d[0];
        split_d = 1'b1;
      end
      default: mdsel_d = 1'b1;
    endcase
  end

  // pad control output flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdsel_q <= 1'b1;
      split_q <= 1'b0;
    end else begin
      mdsel_q <= mdsel_d;
      split_q <= split_d;
    end
  end

  // capture raw on the last clock of each scan step, and arm the update
  // strobe once step 7 has been sampled
  always_comb begin
    sample_en = step_end && (phase_q != PH_IDLE);
    cap0_d    = cap0_q;
    cap1_d    = cap1_q;
    cap5_d    = cap5_q;
    cap6_d    = cap6_q;
    if (sample_en) begin
      case (step_q[2:0])
        3'd0:    cap0_d = raw;
        3'd1:    cap1_d = raw[5:2];
        3'd5:    cap5_d = raw[3:0];
        3'd6:    cap6_d = raw[3:0];
        default: ;
      endcase
    end
    upd_d    = sample_en && (step_q == SCAN_MAX);
    upd_p2_d = (phase_q == PH_P2);
  end

  // capture registers and update strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap0_q   <= '0;
      cap1_q   <= '0;
      cap5_q   <= '0;
      cap6_q   <= '0;
      upd_q    <= 1'b0;
      upd_p2_q <= 1'b0;
    end else begin
      cap0_q   <= cap0_d;
      cap1_q   <= cap1_d;
      cap5_q   <= cap5_d;
      cap6_q   <= cap6_d;
      upd_q    <= upd_d;
      upd_p2_q <= upd_p2_d;
    end
  end

  // decode captured steps into the button word
  // Left+Right both asserted on step 1 is the MD pad signature; all four
  // direction lines low on step 5 identifies a six-button pad, whose step 6
  // carries Z/Y/X/Mode on the direction lines.
  always_comb begin
    present     = cap1_q[0] & cap1_q[1];
    six         = (cap5_q == 4'hF);
    word        = '0;
    word[0]     = cap0_q[3];          // R
    word[1]     = cap0_q[2];          // L
    word[2]     = cap0_q[1];          // D
    word[3]     = cap0_q[0];          // U
    word[4]     = cap0_q[4];          // B
    word[5]     = cap0_q[5];          // C
    word[6]     = cap1_q[2];          // A
    word[7]     = cap1_q[3];          // Start
    if (six) begin
      word[8]   = cap6_q[3];          // Mode
      word[9]   = cap6_q[2];          // X
      word[10]  = cap6_q[1];          // Y
      word[11]  = cap6_q[0];          // Z
    end
    if (!present) word = '0;
  end

  // output words load in one clock for the player just scanned
  always_comb begin
    joy1_d = joy1_q;
    joy2_d = joy2_q;
    if (upd_q) begin
      if (upd_p2_q) joy2_d = word;
      else          joy1_d = word;
    end
  end

  // output word flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy1_q <= '0;
      joy2_q <= '0;
    end else begin
      joy1_q <= joy1_d;
      joy2_q <= joy2_d;
    end
  end

  assign joy_mdsel = mdsel_q;
  assign joy_split = split_q;
  assign joystick1 = joy1_q;
  assign joystick2 = joy2_q;

endmodule

// File: tb/tb_db9md_pad_reader.sv
// Bench for db9md_pad_reader: behavioural pad models on both ports,
// expected button words queued per player and checked at each update.
module tb_db9md_pad_reader;

  localparam int CD = 6;
  localparam int IS = 5;
  localparam int F  = (16 + IS) * CD;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  joy_in;
  logic        joy_mdsel, joy_split;
  logic [15:0] joystick1, joystick2;

  logic        rst_s_n;
  logic [5:0]  joy_none = 6'h3F;
  logic        mdsel_s, split_s;
  logic [15:0] j1_s, j2_s;

  always #5 clk = ~clk;

  db9md_pad_reader #(.CLK_DIV(CD), .IDLE_STEPS(IS)) u_dut (
    .clk(clk), .reset_n(reset_n), .joy_in(joy_in),
    .joy_mdsel(joy_mdsel), .joy_split(joy_split),
    .joystick1(joystick1), .joystick2(joystick2));

  db9md_pad_reader #(.CLK_DIV(4), .IDLE_STEPS(1)) u_small (
    .clk(clk), .reset_n(rst_s_n), .joy_in(joy_none),
    .joy_mdsel(mdsel_s), .joy_split(split_s),
    .joystick1(j1_s), .joystick2(j2_s));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- pad models ----------------
  // pad type: 0 = none, 1 = three-button, 2 = six-button
  // buttons in output-word order: R L D U B C A St M X Y Z
  int          pad_type [2];
  logic [11:0] btns     [2];
  int          falls = 0;
  logic        split_seen = 1'b0;
  logic        mdsel_seen = 1'b1;

  // pad's internal select counter: restarts when the port mux switches
  always @(joy_mdsel or joy_split or reset_n) begin
    if (!reset_n || joy_split != split_seen) falls = 0;
    else if (mdsel_seen && !joy_mdsel)       falls = falls + 1;
    split_seen = joy_split;
    mdsel_seen = joy_mdsel;
  end

  // active-high lines [0]..[5] a real pad pulls low on a given select step
  function automatic logic [5:0] pad_lines(input int typ, input logic [11:0] b, input int step);
    if (typ == 0) return 6'h00;
    if ((step & 1) == 0) begin
      if (typ == 2 && step == 6) return {b[5], b[4], b[8], b[9], b[10], b[11]};
      return {b[5], b[4], b[0], b[1], b[2], b[3]};
    end
    if (typ == 2 && step == 5) return {b[7], b[6], 4'hF};
    return {b[7], b[6], 1'b1, 1'b1, b[2], b[3]};
  endfunction

  always_comb
    joy_in = ~pad_lines(pad_type[joy_split], btns[joy_split],
                        joy_mdsel ? 2 * falls : 2 * falls - 1);

  // word a correctly working reader reports for a pad holding buttons b.
  // A three-button pad holding Up+Down drives all four direction lines low
  // on the third SELECT-low step, so it reads as six-button with U,D,L,R
  // reappearing as Z,Y,X,Mode.
  function automatic logic [15:0] exp_word(input int typ, input logic [11:0] b);
    if (typ == 0) return 16'h0000;
    if (typ == 2) return {4'h0, b};
    return {4'h0, (b[3] && b[2]) ? b[3:0] : 4'h0, b[7:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [15:0] q1[$], q2[$];
  logic [15:0] last1 = '0, last2 = '0;

  task automatic set_cfg(input int t1, input logic [11:0] b1, input int t2, input logic [11:0] b2);
    pad_type[0] = t1; btns[0] = b1;
    pad_type[1] = t2; btns[1] = b2;
    q1.push_back(exp_word(t1, b1));
    q2.push_back(exp_word(t2, b2));
  endtask

  // clocks since reset release
  int tcnt = 0;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) tcnt <= 0;
    else          tcnt <= tcnt + 1;

  function automatic logic exp_mdsel(input int t);
    int s;
    s = (t % F) / CD;
    return (s >= 16) ? 1'b1 : ((s % 2) == 0);
  endfunction

  function automatic logic exp_split(input int t);
    int s;
    s = (t % F) / CD;
    return (s >= 8) && (s < 16);
  endfunction

  // SELECT / mux waveform against frame arithmetic, mid-cycle
  always @(negedge clk) begin
    if (reset_n) begin
      check("mdsel_wave", joy_mdsel, exp_mdsel(tcnt));
      check("split_wave", joy_split, exp_split(tcnt));
    end
  end

  // player 1 monitor: word updates the clock after the mux moves to port 2
  initial forever begin
    @(posedge joy_split);
    #1;
    if (!reset_n) continue;
    check("j1_hold", joystick1, last1);
    @(posedge clk); #1;
    if (!reset_n) continue;
    check("j1_upd_time", tcnt % F, 8 * CD + 1);
    if (q1.size() == 0) begin
      check("j1_unexpected_upd", 1, 0);
    end else begin
      last1 = q1.pop_front();
      check("joystick1", joystick1, last1);
    end
  end

  // player 2 monitor: word updates the clock after the mux returns to port 1
  initial forever begin
    @(negedge joy_split);
    #1;
    if (!reset_n) continue;
    check("j2_hold", joystick2, last2);
    @(posedge clk); #1;
    if (!reset_n) continue;
    check("j2_upd_time", tcnt % F, 16 * CD + 1);
    if (q2.size() == 0) begin
      check("j2_unexpected_upd", 1, 0);
    end else begin
      last2 = q2.pop_front();
      check("joystick2", joystick2, last2);
    end
  end

  task automatic wait_idle();
    logic prev;
    bit   found;
    found = 0;
    prev  = joy_split;
    for (int i = 0; i < 2 * F + 8 && !found; i++) begin
      @(posedge clk); #1;
      if (prev && !joy_split) found = 1;
      prev = joy_split;
    end
    check("idle_reached", found, 1);
  endtask

  // ---------------- small-parameter frame timing ----------------
  task automatic measure_small();
    int   rise_t[$];
    int   highs[$];
    int   hcnt;
    logic prev;
    hcnt = 0;
    prev = 1'b0;
    for (int cyc = 1; cyc <= 5 * 68 + 5; cyc++) begin
      @(posedge clk); #1;
      if (split_s) hcnt++;
      if (split_s && !prev) begin
        rise_t.push_back(cyc);
        check("small_j2_zero", j2_s, 16'h0000);
      end
      if (!split_s && prev) begin
        highs.push_back(hcnt);
        hcnt = 0;
        check("small_j1_zero", j1_s, 16'h0000);
      end
      prev = split_s;
    end
    check("small_rise_count", rise_t.size() >= 4, 1);
    check("small_first_rise", (rise_t.size() > 0) ? rise_t[0] : -1, 32);
    for (int i = 1; i < rise_t.size(); i++)
      check("small_frame_period", rise_t[i] - rise_t[i-1], 68);
    check("small_high_count", highs.size() >= 4, 1);
    for (int i = 0; i < highs.size(); i++)
      check("small_split_high", highs[i], 32);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          t1, t2;
    logic [11:0] b1, b2;
    bit          hit;
    reset_n = 1'b0;
    rst_s_n = 1'b0;
    pad_type[0] = 0; pad_type[1] = 0;
    btns[0] = '0;    btns[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_j1", joystick1, 16'h0000);
    check("rst_j2", joystick2, 16'h0000);
    check("rst_mdsel", joy_mdsel, 1'b1);
    check("rst_split", joy_split, 1'b0);
    check("rst_small_mdsel", mdsel_s, 1'b1);

    @(posedge clk); #2 rst_s_n = 1'b1;
    measure_small();

    // six-button on port 1, nothing held; nothing on port 2
    set_cfg(2, 12'h000, 0, 12'h000);
    @(posedge clk); #2 reset_n = 1'b1;
    wait_idle();
    // six-button: U, A, Start, Mode, X; three-button port 2: B, Right
    set_cfg(2, 12'h3C8, 1, 12'h011);
    wait_idle();
    // no pads at all
    set_cfg(0, 12'h000, 0, 12'h000);
    wait_idle();
    // three-button Up+Down; six-button holding A on port 2
    set_cfg(1, 12'h00C, 2, 12'h040);
    wait_idle();
    set_cfg(2, 12'h001, 2, 12'h040);

    // reset pulse in the middle of player 2 step 4
    hit = 0;
    for (int i = 0; i < F + 4 && !hit; i++) begin
      @(posedge clk); #1;
      if ((tcnt % F) == 12 * CD + 2) hit = 1;
    end
    check("p2_step4_reached", hit, 1);
    check("pre_rst_j2", joystick2, 16'h0040);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_j1", joystick1, 16'h0000);
    check("mid_rst_j2", joystick2, 16'h0000);
    check("mid_rst_mdsel", joy_mdsel, 1'b1);
    check("mid_rst_split", joy_split, 1'b0);
    q1.delete();
    q2.delete();
    last1 = '0;
    last2 = '0;
    set_cfg(2, 12'h001, 2, 12'h040);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    repeat (20) begin
      wait_idle();
      t1 = $urandom_range(0, 2);
      t2 = $urandom_range(0, 2);
      b1 = 12'($urandom);
      b2 = 12'($urandom);
      if (t1 == 1) b1 = b1 & 12'h0FF;
      if (t2 == 1) b2 = b2 & 12'h0FF;
      set_cfg(t1, b1, t2, b2);
    end
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // guard against a stalled run
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: run exceeded time limit, got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
